debounce_pulse: RTL and testbench

Input-conditioning stage that sits directly upstream of the D-type flip-flop stages. It synchronises an asynchronous, bouncy raw input (switch or button) to CLK and filters it with a stability counter. It then presents a clean level on Q, suitable as a flip-flop D input. It also produces one-cycle RISE/FALL pulses, suitable as clock-enable/strobe inputs for downstream registers.

---
 rtl/debounce_pulse.sv | 126 ++++++++++++
 tb/tb_debounce_pulse.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/debounce_pulse.sv
// Synchronise and debounce a bouncy raw input; emit a clean
// registered level plus one-cycle RISE/FALL strobes.
module debounce_pulse #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic CLK,
  input  logic Reset,
  input  logic D_raw,
  output logic Q,
  output logic RISE,
  output logic FALL,
  output logic BUSY
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    S_LOW,
    S_WAIT_HI,
    S_HIGH,
    S_WAIT_LO
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;

  state_t                 w_state_nx;
  logic [CW-1:0]          w_cnt_nx;
  logic                   w_q_nx;
  logic                   w_rise_nx;
  logic                   w_fall_nx;
  logic                   w_busy_nx;
  logic                   w_s;

  assign w_s = r_sync[SYNC_STAGES-1];

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], D_raw};
    end
  end

  // s is tested before the count so a return on the last cycle cancels
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_q_nx     = Q;
    w_rise_nx  = 1'b0;
    w_fall_nx  = 1'b0;
    unique case (r_state)
      S_LOW: begin
        if (w_s) begin
          w_state_nx = S_WAIT_HI;
          w_cnt_nx   = CNT_ONE;
        end else begin
          w_cnt_nx   = '0;
        end
      end
      S_WAIT_HI: begin
        if (!w_s) begin
          w_state_nx = S_LOW;
          w_cnt_nx   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx = S_HIGH;
          w_q_nx     = 1'b1;
          w_rise_nx  = 1'b1;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx   = r_cnt + CNT_ONE;
        end
      end
      S_HIGH: begin
        if (!w_s) begin
          w_state_nx = S_WAIT_LO;
          w_cnt_nx   = CNT_ONE;
        end else begin
          w_cnt_nx   = '0;
        end
      end
      S_WAIT_LO: begin
        if (w_s) begin
          w_state_nx = S_HIGH;
          w_cnt_nx   = '0;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nx = S_LOW;
          w_q_nx     = 1'b0;
          w_fall_nx  = 1'b1;
          w_cnt_nx   = '0;
        end else begin
          w_cnt_nx   = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_nx = S_LOW;
        w_cnt_nx   = '0;
      end
    endcase
    w_busy_nx = (w_state_nx == S_WAIT_HI) ||
                (w_state_nx == S_WAIT_LO);
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state <= S_LOW;
      r_cnt   <= '0;
      Q       <= 1'b0;
      RISE    <= 1'b0;
      FALL    <= 1'b0;
      BUSY    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      Q       <= w_q_nx;
      RISE    <= w_rise_nx;
      FALL    <= w_fall_nx;
      BUSY    <= w_busy_nx;
    end
  end

endmodule

// File: tb/tb_debounce_pulse.sv
// Scoreboard bench for debounce_pulse: default instance and a
// SYNC_STAGES=3 / STABLE_CYCLES=2 instance.
module tb_debounce_pulse;

  logic CLK = 1'b0;
  logic RstA = 1'b1;
  logic DA = 1'b0;
  logic QA, RA, FA, BA;
  logic RstB = 1'b1;
  logic DB = 1'b0;
  logic QB, RB, FB, BB;

  typedef struct {
    int         tid;
    logic [3:0] e;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   tid    = 0;

  always #5 CLK = ~CLK;

  debounce_pulse #(
    .SYNC_STAGES(2),
    .STABLE_CYCLES(4)
  ) u_a (
    .CLK(CLK), .Reset(RstA), .D_raw(DA),
    .Q(QA), .RISE(RA), .FALL(FA), .BUSY(BA)
  );

  debounce_pulse #(
    .SYNC_STAGES(3),
    .STABLE_CYCLES(2)
  ) u_b (
    .CLK(CLK), .Reset(RstB), .D_raw(DB),
    .Q(QB), .RISE(RB), .FALL(FB), .BUSY(BB)
  );

  // Expected nibble is {Q,RISE,FALL,BUSY} after the next rising edge
  task automatic cyc(input logic rst, input logic d,
                     input logic [3:0] e);
    exp_t x;
    @(negedge CLK);
    RstA = rst;
    DA   = d;
    x.tid = tid;
    x.e   = e;
    qa.push_back(x);
  endtask

  task automatic ca(input logic d, input logic [3:0] e);
    cyc(1'b0, d, e);
  endtask

  task automatic cyc2(input logic rst, input logic d,
                      input logic [3:0] e);
    exp_t x;
    @(negedge CLK);
    RstB = rst;
    DB   = d;
    x.tid = tid;
    x.e   = e;
    qb.push_back(x);
  endtask

  task automatic cb(input logic d, input logic [3:0] e);
    cyc2(1'b0, d, e);
  endtask

  initial begin : monitor
    exp_t x;
    logic [3:0] got;
    forever begin
      @(posedge CLK);
      #1;
      if (qa.size() > 0) begin
        x   = qa.pop_front();
        got = {QA, RA, FA, BA};
        n_chk++;
        if (got === x.e) n_pass++;
        else $display("FAIL dutA t%0d QRFB got %b exp %b",
                      x.tid, got, x.e);
      end
      if (qb.size() > 0) begin
        x   = qb.pop_front();
        got = {QB, RB, FB, BB};
        n_chk++;
        if (got === x.e) n_pass++;
        else $display("FAIL dutB t%0d QRFB got %b exp %b",
                      x.tid, got, x.e);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // 1: reset with D_raw=1, then rise 5 edges later
    tid = 1;
    cyc(1, 1, 4'h0); cyc(1, 1, 4'h0);
    ca(1, 4'h0); ca(1, 4'h0); ca(1, 4'h1); ca(1, 4'h1);
    ca(1, 4'h1); ca(1, 4'hC); ca(1, 4'h8); ca(1, 4'h8);
    ca(1, 4'h8);
    // 2: clean fall, rise, fall
    tid = 2;
    ca(0, 4'h8); ca(0, 4'h8); ca(0, 4'h9); ca(0, 4'h9);
    ca(0, 4'h9); ca(0, 4'h2); ca(0, 4'h0); ca(0, 4'h0);
    ca(1, 4'h0); ca(1, 4'h0); ca(1, 4'h1); ca(1, 4'h1);
    ca(1, 4'h1); ca(1, 4'hC); ca(1, 4'h8); ca(1, 4'h8);
    ca(0, 4'h8); ca(0, 4'h8); ca(0, 4'h9); ca(0, 4'h9);
    ca(0, 4'h9); ca(0, 4'h2); ca(0, 4'h0); ca(0, 4'h0);
    // 3: bounce rejected
    tid = 3;
    ca(1, 4'h0); ca(0, 4'h0); ca(1, 4'h1); ca(1, 4'h0);
    ca(0, 4'h1); ca(0, 4'h1); ca(0, 4'h0); ca(0, 4'h0);
    ca(0, 4'h0);
    // 4: bounce then settle, single RISE
    tid = 4;
    ca(1, 4'h0); ca(0, 4'h0); ca(1, 4'h1); ca(1, 4'h0);
    ca(1, 4'h1); ca(1, 4'h1); ca(1, 4'h1); ca(1, 4'hC);
    ca(1, 4'h8); ca(1, 4'h8);
    // 5: reset mid-qualification from Q=1, no FALL
    tid = 5;
    ca(0, 4'h8); ca(0, 4'h8); ca(0, 4'h9);
    cyc(1, 0, 4'h0);
    ca(0, 4'h0); ca(0, 4'h0); ca(0, 4'h0);
    ca(0, 4'h0); ca(0, 4'h0); ca(0, 4'h0);
    // 6: return on exact qualifying cycle cancels
    tid = 6;
    ca(1, 4'h0); ca(1, 4'h0); ca(1, 4'h1); ca(0, 4'h1);
    ca(0, 4'h1); ca(0, 4'h0); ca(0, 4'h0); ca(0, 4'h0);
    // 7: continuous toggling never changes Q
    tid = 7;
    for (int i = 0; i < 5; i++) begin
      ca(1, (i == 0) ? 4'h0 : 4'h1);
      ca(0, 4'h0);
    end
    ca(0, 4'h1); ca(0, 4'h0); ca(0, 4'h0);
    // 8: SYNC_STAGES=3, STABLE_CYCLES=2
    tid = 8;
    cyc2(1, 0, 4'h0); cyc2(1, 0, 4'h0);
    cb(1, 4'h0); cb(0, 4'h0); cb(0, 4'h0); cb(1, 4'h1);
    cb(0, 4'h0); cb(0, 4'h0); cb(0, 4'h1); cb(0, 4'h0);
    cb(0, 4'h0);
    cb(1, 4'h0); cb(1, 4'h0); cb(1, 4'h0); cb(1, 4'h1);
    cb(1, 4'hC); cb(1, 4'h8);
    cb(0, 4'h8); cb(0, 4'h8); cb(0, 4'h8); cb(0, 4'h9);
    cb(0, 4'h2); cb(0, 4'h0);
    @(posedge CLK);
    #3;
    n_chk++;
    if (qa.size() == 0 && qb.size() == 0) n_pass++;
    else $display("FAIL drain qa=%0d qb=%0d exp 0",
                  qa.size(), qb.size());
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
